// File: rtl/dmem_access_ctrl_pkg.sv
// Shared encodings for the data-memory access controller.
// funct3 width codes, mcause values for memory traps, FSM states.
// No logic; imported by the controller and its alignment unit.
package dmem_access_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_access_ctrl_lsu_align.sv
// Byte-lane steering: store byte enables/replicated data, load extract/extend, width checks.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the controller decides when the results are used.
module dmem_access_ctrl_lsu_align
  import dmem_access_ctrl_pkg::*;
(
  input  logic [2:0]  f3,
  input  logic        is_store,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] ext_rdata,
  output logic        misalign,
  output logic        illegal
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  // Bring the addressed byte / halfword down to bit 0 for extension.
  assign byte_sh = rdata >> {lane, 3'b000};
  assign half_sh = rdata >> {lane[1], 4'b0000};

  // Decode width, produce lane controls and the extended load value.
  always_comb begin
    be         = 4'b0000;
    lane_wdata = wdata;
    ext_rdata  = rdata;
    misalign   = 1'b0;
    illegal    = 1'b0;
    case (f3)
      F3_B, F3_BU: begin
        illegal    = is_store && (f3 == F3_BU);
        be         = 4'b0001 << lane;
        lane_wdata = {4{wdata[7:0]}};
        ext_rdata  = (f3 == F3_B) ? {{24{byte_sh[7]}}, byte_sh[7:0]}
                                  : {24'd0, byte_sh[7:0]};
      end
      F3_H, F3_HU: begin
        illegal    = is_store && (f3 == F3_HU);
        misalign   = lane[0];
        be         = 4'b0011 << {lane[1], 1'b0};
        lane_wdata = {2{wdata[15:0]}};
        ext_rdata  = (f3 == F3_H) ? {{16{half_sh[15]}}, half_sh[15:0]}
                                  : {16'd0, half_sh[15:0]};
      end
      F3_W: begin
        misalign = |lane;
        be       = 4'hF;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Runs each load/store as a single-beat bus transfer and raises memory traps to the core.
// Latency: request issued the cycle after decode; data in DONE one cycle after ack (ack in first REQ cycle -> 2 stall cycles).
// Backpressure: o_Stall holds the pipeline from acceptance until ack; faults and traps release it immediately.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_MemRead,
  input  logic              i_MemWrite,
  input  logic [2:0]        i_f3,
  input  logic [ADDR_W-1:0] i_Addr,
  input  logic [31:0]       i_WrData,
  output logic              o_Stall,
  output logic [31:0]       o_RdData,
  output logic              o_Ex,
  output logic [3:0]        o_ExCause,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [31:0]       o_bus_wdata,
  output logic [3:0]        o_bus_be,
  input  logic              i_bus_ack,
  input  logic [31:0]       i_bus_rdata,
  input  logic              i_bus_err
);

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_t      state;
  logic [7:0]  cnt;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;

  logic        any_req;
  logic [2:0]  al_f3;
  logic [1:0]  al_lane;
  logic        al_store;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_misalign;
  logic        al_illegal;
  logic        go;
  logic        timeout;
  logic        fault;

  assign any_req = i_MemRead | i_MemWrite;

  // While a transfer is in flight the aligner must see the captured access, not the live pipeline.
  assign al_f3    = (state == ST_REQ) ? f3_q     : i_f3;
  assign al_lane  = (state == ST_REQ) ? lane_q   : i_Addr[1:0];
  assign al_store = (state == ST_REQ) ? o_bus_we : i_MemWrite;

  dmem_access_ctrl_lsu_align u_align (
    .f3         (al_f3),
    .is_store   (al_store),
    .lane       (al_lane),
    .wdata      (i_WrData),
    .rdata      (i_bus_rdata),
    .be         (al_be),
    .lane_wdata (al_wdata),
    .ext_rdata  (al_rdata),
    .misalign   (al_misalign),
    .illegal    (al_illegal)
  );

  assign go      = (state == ST_IDLE) && any_req && !al_illegal && !al_misalign;
  assign timeout = (cnt == TO_CNT);
  // Error beats ack; a timeout coinciding with a real ack lets the ack complete.
  assign fault   = i_bus_err || (timeout && !i_bus_ack);

  // Stall from acceptance through the ack cycle; a faulting cycle releases the core.
  assign o_Stall = go || ((state == ST_REQ) && !fault);

  // Access FSM with registered bus signals, load result and trap pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      cnt         <= 8'd0;
      f3_q        <= 3'd0;
      lane_q      <= 2'd0;
      o_bus_req   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_wdata <= 32'd0;
      o_bus_be    <= 4'd0;
      o_RdData    <= 32'd0;
      o_Ex        <= 1'b0;
      o_ExCause   <= 4'd0;
    end else begin
      o_Ex <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            if (al_illegal) begin
              o_Ex      <= 1'b1;
              o_ExCause <= CAUSE_ILLEGAL;
            end else if (al_misalign) begin
              o_Ex      <= 1'b1;
              o_ExCause <= i_MemWrite ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
            end else begin
              o_bus_addr  <= {i_Addr[ADDR_W-1:2], 2'b00};
              o_bus_we    <= i_MemWrite;
              o_bus_wdata <= al_wdata;
              o_bus_be    <= al_be;
              f3_q        <= i_f3;
              lane_q      <= i_Addr[1:0];
              o_bus_req   <= 1'b1;
              cnt         <= 8'd1;
              state       <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          cnt <= cnt + 8'd1;
          if (fault) begin
            o_bus_req <= 1'b0;
            o_Ex      <= 1'b1;
            o_ExCause <= o_bus_we ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
            cnt       <= 8'd0;
            state     <= ST_IDLE;
          end else if (i_bus_ack) begin
            o_bus_req <= 1'b0;
            if (!o_bus_we) o_RdData <= al_rdata;
            cnt       <= 8'd0;
            state     <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: expected bus beats, load results and traps are queued
// by the stimulus and consumed by an independent monitor when the DUT presents them.
// A behavioural bus responder supplies ack/err with a programmable delay.
module tb_dmem_access_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_MemRead, i_MemWrite;
  logic [2:0]  i_f3;
  logic [31:0] i_Addr, i_WrData;
  logic        o_Stall;
  logic [31:0] o_RdData;
  logic        o_Ex;
  logic [3:0]  o_ExCause;
  logic        o_bus_req, o_bus_we;
  logic [31:0] o_bus_addr, o_bus_wdata;
  logic [3:0]  o_bus_be;
  logic        i_bus_ack, i_bus_err;
  logic [31:0] i_bus_rdata;

  always #5 i_clk = ~i_clk;

  dmem_access_ctrl #(.ADDR_W(32), .TIMEOUT(255)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite), .i_f3(i_f3),
    .i_Addr(i_Addr), .i_WrData(i_WrData),
    .o_Stall(o_Stall), .o_RdData(o_RdData), .o_Ex(o_Ex), .o_ExCause(o_ExCause),
    .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
    .o_bus_wdata(o_bus_wdata), .o_bus_be(o_bus_be),
    .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata), .i_bus_err(i_bus_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  logic [31:0] rd_q[$];
  logic [3:0]  ex_q[$];
  logic [31:0] resp_q[$];

  int checks = 0;
  int errors = 0;

  int ack_dly   = 0;
  bit never_ack = 1'b0;
  bit err_on    = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    errors++;
    $display("FAIL %s unexpected event (nothing queued)", nm);
  endtask

  // Bus responder: ack (optionally with err) on the ack_dly-th cycle of a request.
  initial begin
    int rcnt;
    rcnt = 0;
    i_bus_ack = 1'b0; i_bus_err = 1'b0; i_bus_rdata = 32'd0;
    forever begin
      @(negedge i_clk);
      i_bus_ack = 1'b0;
      i_bus_err = 1'b0;
      if (o_bus_req && i_rst_n) begin
        if (!never_ack && rcnt == ack_dly) begin
          i_bus_ack   = 1'b1;
          i_bus_err   = err_on;
          i_bus_rdata = (resp_q.size() != 0) ? resp_q.pop_front() : 32'd0;
        end
        rcnt++;
      end else begin
        rcnt = 0;
      end
    end
  end

  // Monitor: compare every bus beat, load retirement and trap against the queues.
  initial begin
    bit rd_pend;
    bus_exp_t e;
    rd_pend = 1'b0;
    forever begin
      @(negedge i_clk);
      #1;
      if (!i_rst_n) begin
        rd_pend = 1'b0;
        continue;
      end
      if (rd_pend) begin
        rd_pend = 1'b0;
        if (rd_q.size() == 0) unexpected("rddata");
        else chk("rddata", o_RdData, rd_q.pop_front());
      end
      if (o_bus_req && (i_bus_ack || i_bus_err)) begin
        if (bus_q.size() == 0) unexpected("bus_beat");
        else begin
          e = bus_q.pop_front();
          chk("bus_addr", o_bus_addr, e.addr);
          chk("bus_we", {31'd0, o_bus_we}, {31'd0, e.we});
          if (e.we) begin
            chk("bus_be", {28'd0, o_bus_be}, {28'd0, e.be});
            chk("bus_wdata", o_bus_wdata, e.wdata);
          end
        end
        if (i_bus_ack && !i_bus_err && !o_bus_we) rd_pend = 1'b1;
      end
      if (o_Ex) begin
        chk("ex_without_req", {31'd0, o_bus_req}, 32'd0);
        if (ex_q.size() == 0) unexpected("ex");
        else chk("ex_cause", {28'd0, o_ExCause}, {28'd0, ex_q.pop_front()});
      end
    end
  end

  // Present one memory instruction and hold it until the controller releases the stall.
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output int stalls, output int reqs);
    bit done;
    stalls = 0; reqs = 0; done = 1'b0;
    @(negedge i_clk);
    i_MemRead = rd; i_MemWrite = wr; i_f3 = f3; i_Addr = addr; i_WrData = wd;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (o_bus_req) reqs++;
      if (!o_Stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
      @(negedge i_clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL stall_release actual=stuck required=release within 400 cycles");
    end
  endtask

  task automatic idle_bus();
    @(negedge i_clk);
    i_MemRead = 1'b0; i_MemWrite = 1'b0; i_f3 = 3'd0; i_Addr = 32'd0; i_WrData = 32'd0;
  endtask

  function automatic bus_exp_t bx(input logic [31:0] a, input logic we,
                                  input logic [3:0] be, input logic [31:0] wd);
    bus_exp_t r;
    r.addr = a; r.we = we; r.be = be; r.wdata = wd;
    return r;
  endfunction

  initial begin
    int s, r, s2, r2;
    i_rst_n = 1'b0;
    i_MemRead = 1'b0; i_MemWrite = 1'b0; i_f3 = 3'd0; i_Addr = 32'd0; i_WrData = 32'd0;
    repeat (2) @(negedge i_clk);
    #1;
    chk("rst_req", {31'd0, o_bus_req}, 32'd0);
    chk("rst_ex", {31'd0, o_Ex}, 32'd0);
    chk("rst_cause", {28'd0, o_ExCause}, 32'd0);
    chk("rst_rdata", o_RdData, 32'd0);
    chk("rst_stall", {31'd0, o_Stall}, 32'd0);
    chk("rst_be", {28'd0, o_bus_be}, 32'd0);
    chk("rst_addr", o_bus_addr, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // LB 0x103, ack in first REQ cycle
    ack_dly = 0;
    resp_q.push_back(32'h80AA_BBCC);
    bus_q.push_back(bx(32'h100, 1'b0, 4'h0, 32'h0));
    rd_q.push_back(32'hFFFF_FF80);
    issue(1, 0, 3'b000, 32'h103, 32'h0, s, r);
    chk("lb_stall_cycles", s, 2);
    chk("lb_req_cycles", r, 1);
    idle_bus();

    // SH 0x202
    bus_q.push_back(bx(32'h200, 1'b1, 4'b1100, 32'h5678_5678));
    issue(0, 1, 3'b001, 32'h202, 32'h1234_5678, s, r);
    chk("sh_stall_cycles", s, 2);
    idle_bus();
    repeat (2) @(negedge i_clk);
    #1 chk("sh_keeps_rdata", o_RdData, 32'hFFFF_FF80);

    // SB 0x7: top lane
    bus_q.push_back(bx(32'h4, 1'b1, 4'b1000, 32'hABAB_ABAB));
    issue(0, 1, 3'b000, 32'h7, 32'h0000_00AB, s, r);
    idle_bus();

    // LH 0x22 sign-extends upper half; LBU 0x31 zero-extends lane 1
    resp_q.push_back(32'h8001_7FFF);
    bus_q.push_back(bx(32'h20, 1'b0, 4'h0, 32'h0));
    rd_q.push_back(32'hFFFF_8001);
    issue(1, 0, 3'b001, 32'h22, 32'h0, s, r);
    idle_bus();
    resp_q.push_back(32'h1234_99AA);
    bus_q.push_back(bx(32'h30, 1'b0, 4'h0, 32'h0));
    rd_q.push_back(32'h0000_0099);
    issue(1, 0, 3'b100, 32'h31, 32'h0, s, r);
    idle_bus();

    // LW misaligned
    ex_q.push_back(4'd4);
    issue(1, 0, 3'b010, 32'h101, 32'h0, s, r);
    chk("lw_mis_stall", s, 0);
    chk("lw_mis_req", r, 0);
    idle_bus();
    repeat (2) @(negedge i_clk);

    // Illegal widths: load f3=011, store f3=100
    ex_q.push_back(4'd2);
    issue(1, 0, 3'b011, 32'h40, 32'h0, s, r);
    chk("ld_illegal_stall", s, 0);
    idle_bus();
    ex_q.push_back(4'd2);
    issue(0, 1, 3'b100, 32'h40, 32'h0, s, r);
    chk("st_illegal_req", r, 0);
    idle_bus();
    repeat (2) @(negedge i_clk);

    // SW with no ack: timeout fault
    never_ack = 1'b1;
    ex_q.push_back(4'd7);
    issue(0, 1, 3'b010, 32'h300, 32'hDEAD_BEEF, s, r);
    chk("sw_timeout_req_cycles", r, 255);
    chk("sw_timeout_stall", s, 255);
    idle_bus();
    never_ack = 1'b0;
    repeat (2) @(negedge i_clk);

    // LHU 0x2 with ack+err together
    err_on = 1'b1;
    resp_q.push_back(32'h1111_2222);
    bus_q.push_back(bx(32'h0, 1'b0, 4'h0, 32'h0));
    ex_q.push_back(4'd5);
    issue(1, 0, 3'b101, 32'h2, 32'h0, s, r);
    chk("lhu_err_stall", s, 1);
    idle_bus();
    err_on = 1'b0;
    repeat (2) @(negedge i_clk);
    #1 chk("err_keeps_rdata", o_RdData, 32'hFFFF_8001 & 32'hFFFF_FFFF ^ 32'hFFFF_8001 ^ 32'h0000_0099);

    // Reset while in REQ
    never_ack = 1'b1;
    @(negedge i_clk);
    i_MemRead = 1'b1; i_f3 = 3'b010; i_Addr = 32'h40;
    repeat (3) @(negedge i_clk);
    #3;
    i_MemRead = 1'b0; i_f3 = 3'd0; i_Addr = 32'd0;
    i_rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, o_bus_req}, 32'd0);
    chk("async_rst_ex", {31'd0, o_Ex}, 32'd0);
    @(negedge i_clk);
    never_ack = 1'b0;
    i_rst_n = 1'b1;
    #1 chk("post_rst_rdata", o_RdData, 32'd0);
    resp_q.push_back(32'hCAFE_F00D);
    bus_q.push_back(bx(32'h0, 1'b0, 4'h0, 32'h0));
    rd_q.push_back(32'hCAFE_F00D);
    issue(1, 0, 3'b010, 32'h0, 32'h0, s, r);
    chk("post_rst_lw_stall", s, 2);
    idle_bus();

    // Back-to-back LW, ack delay 3
    ack_dly = 3;
    resp_q.push_back(32'h0102_0304);
    resp_q.push_back(32'h0506_0708);
    bus_q.push_back(bx(32'h10, 1'b0, 4'h0, 32'h0));
    bus_q.push_back(bx(32'h14, 1'b0, 4'h0, 32'h0));
    rd_q.push_back(32'h0102_0304);
    rd_q.push_back(32'h0506_0708);
    issue(1, 0, 3'b010, 32'h10, 32'h0, s, r);
    issue(1, 0, 3'b010, 32'h14, 32'h0, s2, r2);
    chk("b2b_first_stall", s, 5);
    chk("b2b_second_stall", s2, 5);
    chk("b2b_second_req", r2, 4);
    idle_bus();

    repeat (6) @(negedge i_clk);
    chk("bus_q_drained", bus_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    chk("ex_q_drained", ex_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
